// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move controller: FSM state type,
// half-step coil table and default timing parameters.
package stepper_pkg;

  // 1 ms at 50 MHz between half-steps.
  localparam int unsigned MIN_PERIOD_DEFAULT      = 50000;
  // 0.5 s at 50 MHz of idle hold before the coils are released.
  localparam int unsigned IDLE_OFF_CYCLES_DEFAULT = 25000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Coil patterns {JA1,JA2,JA3,JA4} for half-step index 0..7.
  localparam logic [3:0] HALF_STEP_TABLE [8] = '{
    4'b0100, 4'b0101, 4'b0001, 4'b1001,
    4'b1000, 4'b1010, 4'b0010, 4'b0110
  };

endpackage

// File: rtl/stepper_period_timer.sv
// Half-step period timer.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : clear the count and capture period
//   period     : clocks per half-step (captured on load)
//   enable     : count while high
//   strobe     : high in the clock where the count reaches period-1
module stepper_period_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [19:0] period,
  input  logic        enable,
  output logic        strobe
);

  logic [19:0] r_period;
  logic [19:0] r_count;

  assign strobe = enable && (r_count == r_period - 20'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_period <= period;
      r_count  <= '0;
    end else if (enable) begin
      r_count <= strobe ? '0 : r_count + 20'd1;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: accepts move commands (direction, half-step
// count, period), drives the half-step coil sequence and tracks position.
//   CLK50MHZ, reset  : clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake (ready only while idle)
//   cmd_dir/steps/period : move direction, half-step count, clocks per step
//   abort            : cancel the move in progress
//   coils            : {JA1,JA2,JA3,JA4}, released after idle timeout
//   busy/done/aborted: move status and one-cycle completion pulses
//   position         : signed half-step position
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned MIN_PERIOD      = MIN_PERIOD_DEFAULT,
  parameter int unsigned IDLE_OFF_CYCLES = IDLE_OFF_CYCLES_DEFAULT
) (
  input  logic        CLK50MHZ,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic [19:0] cmd_period,
  input  logic        abort,
  output logic [3:0]  coils,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] position
);

  localparam logic [19:0]  MIN_P     = 20'(MIN_PERIOD);
  localparam int unsigned  IW        = $clog2(IDLE_OFF_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_OFF_CYCLES - 1);

  state_t        r_state, w_next_state;
  logic [2:0]    r_index;
  logic [15:0]   r_position;
  logic [15:0]   r_remaining;
  logic          r_dir;
  logic [IW-1:0] r_idle_cnt;
  logic [3:0]    r_coils;
  logic          r_busy, r_done, r_aborted, r_ready;

  logic          w_transfer, w_start, w_zero, w_abort, w_step, w_last;
  logic          w_strobe;
  logic [19:0]   w_eff_period;
  logic [2:0]    w_index_next;
  logic [15:0]   w_position_next;

  assign w_eff_period = (cmd_period < MIN_P) ? MIN_P : cmd_period;

  stepper_period_timer u_timer (
    .clk    (CLK50MHZ),
    .reset  (reset),
    .load   (w_start),
    .period (w_eff_period),
    .enable (r_state == ST_RUN),
    .strobe (w_strobe)
  );

  always_comb begin
    w_next_state    = r_state;
    w_transfer      = cmd_valid && r_ready;
    w_start         = w_transfer && (cmd_steps != 16'd0);
    w_zero          = w_transfer && (cmd_steps == 16'd0);
    w_abort         = (r_state == ST_RUN) && abort;
    // Abort takes priority over a coincident step boundary.
    w_step          = (r_state == ST_RUN) && !abort && w_strobe;
    w_last          = w_step && (r_remaining == 16'd1);
    w_index_next    = r_dir ? r_index + 3'd1 : r_index - 3'd1;
    w_position_next = r_dir ? r_position + 16'd1 : r_position - 16'd1;
    case (r_state)
      ST_IDLE: if (w_start)           w_next_state = ST_RUN;
      ST_RUN:  if (w_abort || w_last) w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      r_index     <= '0;
      r_position  <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_idle_cnt  <= '0;
      r_coils     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_busy    <= (w_next_state == ST_RUN);
      r_ready   <= (w_next_state == ST_IDLE);
      r_done    <= w_last || w_zero;
      r_aborted <= w_abort;

      if (w_start) begin
        r_dir       <= cmd_dir;
        r_remaining <= cmd_steps;
        r_coils     <= HALF_STEP_TABLE[r_index];
      end else if (w_step) begin
        r_index     <= w_index_next;
        r_position  <= w_position_next;
        r_remaining <= r_remaining - 16'd1;
        r_coils     <= HALF_STEP_TABLE[w_index_next];
      end else if ((r_state == ST_IDLE) && (r_idle_cnt == IDLE_LAST)) begin
        r_coils <= '0;
      end

      // Idle hold counter restarts only when leaving RUN; it saturates.
      if ((r_state == ST_RUN) && (w_next_state == ST_IDLE))
        r_idle_cnt <= '0;
      else if ((r_state == ST_IDLE) && (r_idle_cnt != IDLE_LAST))
        r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign coils     = r_coils;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign cmd_ready = r_ready;
  assign position  = r_position;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
module tb_stepper_move_ctrl;

  localparam int MINP     = 20;
  localparam int IDLE_OFF = 100;

  logic        CLK50MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [19:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic [3:0]  coils;
  logic        busy, done, aborted;
  logic [15:0] position;

  stepper_move_ctrl #(.MIN_PERIOD(MINP), .IDLE_OFF_CYCLES(IDLE_OFF)) dut (
    .CLK50MHZ  (CLK50MHZ),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .coils     (coils),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .position  (position)
  );

  always #5 CLK50MHZ = ~CLK50MHZ;

  // Reference model: coil table, position, cycle-based idle timeout.
  logic [3:0] tbl [8] = '{4'b0100, 4'b0101, 4'b0001, 4'b1001,
                          4'b1000, 4'b1010, 4'b0010, 4'b0110};
  int  m_idx = 0;
  int  m_pos = 0;
  bit  m_energized = 0;
  int  m_cyc = 0;
  int  m_idle_entry = 0;
  int  n_chk = 0;
  int  n_err = 0;

  task automatic tick();
    @(posedge CLK50MHZ);
    #1;
    m_cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] idle_coils();
    if (!m_energized) return 4'b0000;
    if (m_cyc - m_idle_entry >= IDLE_OFF) return 4'b0000;
    return tbl[m_idx];
  endfunction

  function automatic logic [31:0] pos32();
    return {16'h0, 16'(m_pos)};
  endfunction

  task automatic model_step(input bit dir);
    m_idx = (m_idx + (dir ? 1 : 7)) % 8;
    m_pos = dir ? m_pos + 1 : m_pos - 1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    m_idx = 0; m_pos = 0; m_energized = 0;
    chk("rst_coils", {28'h0, coils}, 32'h0);
    chk("rst_pos", {16'h0, position}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_aborted", {31'h0, aborted}, 32'h0);
    chk("rst_ready", {31'h0, cmd_ready}, 32'h0);
    reset = 1'b0;
    tick();
    chk("rel_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rel_coils", {28'h0, coils}, 32'h0);
  endtask

  // Issues one command and follows it to completion against the model.
  task automatic run_move(input bit dir, input int steps, input int period, input bit keep);
    int eff;
    logic [3:0] cur;
    eff = (period < MINP) ? MINP : period;
    chk("pre_ready", {31'h0, cmd_ready}, 32'h1);
    cmd_dir = dir; cmd_steps = 16'(steps); cmd_period = 20'(period);
    cmd_valid = 1'b1;
    tick();
    if (!keep) cmd_valid = 1'b0;
    if (steps == 0) begin
      chk("zero_done", {31'h0, done}, 32'h1);
      chk("zero_busy", {31'h0, busy}, 32'h0);
      chk("zero_ready", {31'h0, cmd_ready}, 32'h1);
      chk("zero_coils", {28'h0, coils}, {28'h0, idle_coils()});
      chk("zero_pos", {16'h0, position}, pos32());
      tick();
      chk("zero_done_clr", {31'h0, done}, 32'h0);
      return;
    end
    m_energized = 1;
    cur = tbl[m_idx];
    chk("start_coils", {28'h0, coils}, {28'h0, cur});
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_ready", {31'h0, cmd_ready}, 32'h0);
    for (int k = 1; k <= steps; k++) begin
      repeat (eff - 1) tick();
      chk("pre_step_coils", {28'h0, coils}, {28'h0, cur});
      chk("pre_step_done", {31'h0, done}, 32'h0);
      chk("pre_step_ready", {31'h0, cmd_ready}, 32'h0);
      tick();
      model_step(dir);
      cur = tbl[m_idx];
      chk("step_coils", {28'h0, coils}, {28'h0, cur});
      chk("step_pos", {16'h0, position}, pos32());
      chk("step_done", {31'h0, done}, {31'h0, k == steps});
      chk("step_busy", {31'h0, busy}, {31'h0, k != steps});
    end
    m_idle_entry = m_cyc;
    chk("end_ready", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    // Reset state.
    do_reset(3);

    // Forward 3 half-steps at the minimum period.
    run_move(1'b1, 3, MINP, 1'b0);
    chk("fwd3_coils_literal", {28'h0, coils}, 32'h9);
    chk("fwd3_pos_literal", {16'h0, position}, 32'd3);
    tick();
    chk("done_one_cycle", {31'h0, done}, 32'h0);

    // Reverse 2 from index 0.
    do_reset(2);
    run_move(1'b0, 1, MINP, 1'b0);
    chk("rev_coils_7", {28'h0, coils}, 32'h6);
    run_move(1'b0, 1, MINP, 1'b0);
    chk("rev_coils_6", {28'h0, coils}, 32'h2);
    chk("rev_pos_literal", {16'h0, position}, 32'hFFFE);

    // Period below minimum is clamped; zero-step command.
    run_move(1'b1, 2, 10, 1'b0);
    run_move(1'b1, 0, 30, 1'b0);

    // Abort exactly on a step boundary of a 5-step move.
    cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 20'd25; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (25) tick();
    model_step(1'b1);
    chk("abort_pre_pos", {16'h0, position}, pos32());
    repeat (24) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_idle_entry = m_cyc;
    chk("abort_pulse", {31'h0, aborted}, 32'h1);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_pos", {16'h0, position}, pos32());
    chk("abort_coils", {28'h0, coils}, {28'h0, tbl[m_idx]});
    chk("abort_ready", {31'h0, cmd_ready}, 32'h1);
    tick();
    chk("abort_pulse_clr", {31'h0, aborted}, 32'h0);
    chk("abort_no_late_step", {16'h0, position}, pos32());

    // Abort while idle is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_pulse", {31'h0, aborted}, 32'h0);
    chk("idle_abort_busy", {31'h0, busy}, 32'h0);
    chk("idle_abort_ready", {31'h0, cmd_ready}, 32'h1);

    // Command held valid through a move; next one accepted right after.
    run_move(1'b1, 2, MINP, 1'b1);
    run_move(1'b0, 1, 30, 1'b0);

    // Idle timeout releases the coils.
    repeat (IDLE_OFF - 1) tick();
    chk("idle_hold_coils", {28'h0, coils}, {28'h0, idle_coils()});
    chk("idle_hold_nonzero", {31'h0, coils != 4'b0000}, 32'h1);
    tick();
    chk("idle_off_coils", {28'h0, coils}, 32'h0);

    // Randomized moves with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      int gap;
      run_move(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 40)), 1'b0);
      gap = int'($urandom_range(0, 150));
      repeat (gap) tick();
      chk("rand_idle_coils", {28'h0, coils}, {28'h0, idle_coils()});
      chk("rand_idle_pos", {16'h0, position}, pos32());
    end

    // Reset in the middle of a move.
    cmd_dir = 1'b1; cmd_steps = 16'd4; cmd_period = 20'(MINP); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (MINP + 3) tick();
    reset = 1'b1;
    tick();
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_aborted", {31'h0, aborted}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    do_reset(2);
    chk("midrst_pos", {16'h0, position}, 32'h0);
    chk("post_done", {31'h0, done}, 32'h0);
    chk("post_aborted", {31'h0, aborted}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 SHALL have parameter MIN_PERIOD, default 50000, minimum clocks between half-steps (1 ms at 50 MHz).
REQ-002 SHALL have parameter IDLE_OFF_CYCLES, default 25000000, clocks of idle hold before coils de-energize (0.5 s).
REQ-003 SHALL have port CLK50MHZ  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  move command present.
REQ-006 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_dir  input  1  1 = forward, 0 = reverse.
REQ-008 SHALL have port cmd_steps  input  16  half-steps to execute, unsigned.
REQ-009 SHALL have port cmd_period  input  20  clocks per half-step, unsigned.
REQ-010 SHALL have port abort  input  1  cancels the move in progress.
REQ-011 SHALL have port coils  output  4  driver lines in order {JA1,JA2,JA3,JA4}.
REQ-012 SHALL have port busy  output  1  move in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse on normal move completion.
REQ-014 SHALL have port aborted  output  1  one-cycle pulse on abort.
REQ-015 SHALL have port position  output  16  signed half-step position, two's complement.

Function
REQ-016 SHALL use the 8-entry half-step table, index 0..7: 0100, 0101, 0001, 1001, 1000, 1010, 0010, 0110.
REQ-017 SHALL step forward as index+1 mod 8 and reverse as index-1 mod 8; 7->0 and 0->7 wrap.
REQ-018 SHALL use states IDLE and RUN only.
REQ-019 SHALL drive cmd_ready=1 exactly when state=IDLE; transfer occurs when cmd_valid and cmd_ready are both 1.
REQ-020 SHALL, on transfer with cmd_steps=0, stay IDLE, pulse done next cycle, and leave index, position and coils unchanged.
REQ-021 SHALL, on transfer with cmd_steps>0, enter RUN next cycle; latch dir, steps and effective period = max(cmd_period, MIN_PERIOD); load period counter 0; set coils = table[index] on the same cycle.
REQ-022 SHALL, in RUN, advance the counter each clock; when counter = period-1: update index, position ±1 (wrapping), decrement remaining, clear counter.
REQ-023 SHALL place the first step exactly period clocks after the transfer cycle and space subsequent steps exactly period clocks apart.
REQ-024 SHALL, on the step that makes remaining 0, return to IDLE and pulse done in the same cycle the final coil value appears.
REQ-025 SHALL drive busy=1 exactly when state=RUN.
REQ-026 SHALL, on abort=1 in RUN, go IDLE next cycle with no further steps and pulse aborted; abort wins over a coincident step boundary, so no step occurs.
REQ-027 SHALL ignore abort in IDLE: no pulse and no state change.
REQ-028 SHALL, in IDLE, hold coils = table[index] for IDLE_OFF_CYCLES clocks, then drive 0000; the idle counter restarts on each entry to IDLE.
REQ-029 SHALL never let done and aborted be 1 in the same cycle.

Reset
REQ-030 SHALL, while reset=1, force state=IDLE, index=0, position=0, counters=0, coils=0000, busy=0, done=0, aborted=0, cmd_ready=0.
REQ-031 SHALL, on reset asserted mid-move, terminate the move with no done or aborted pulse; cmd_ready=1 on the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the half-step table constant, state encoding and the MIN_PERIOD/IDLE_OFF_CYCLES defaults in shared package stepper_pkg.
REQ-033 SHALL implement the period counter and step-strobe as one sub-module, stepper_period_timer (inputs load/period/enable, output strobe).
REQ-034 SHALL register all outputs, with no combinational path from inputs to coils.

Verification
REQ-035 SHALL cover: reset, then fwd, steps=3, period=50000 -> steps at +50000/+100000/+150000 clocks; coils 0101, 0001, 1001; position=3; done at the third step.
REQ-036 SHALL cover: from index 0, rev, steps=2 -> coils 0110 then 0010; position=-2 (0xFFFE).
REQ-037 SHALL cover: cmd_period=10 -> step spacing 50000 clocks (clamped to MIN_PERIOD); cmd_steps=0 -> done the next cycle with no coil change.
REQ-038 SHALL cover: abort on the exact step-boundary cycle of a 5-step move -> no step, aborted pulse, busy=0, position unchanged.
REQ-039 SHALL cover: cmd_valid held during RUN -> cmd_ready=0 and no transfer until done; the command is accepted the cycle after IDLE is entered.
REQ-040 SHALL cover: after done, IDLE_OFF_CYCLES elapse -> coils=0000; reset mid-move -> coils=0000, position=0, no done or aborted pulse.
